// File: rtl/uart_ocram_pkg.sv
// rtl/uart_ocram_pkg.sv - shared types and constants for the on-chip RAM arbiter
package uart_ocram_pkg;

  localparam int ADDR_W_DEF = 15;
  localparam int DATA_W_DEF = 32;
  localparam int BE_W_DEF   = DATA_W_DEF / 8;

  localparam int PRIO_RR    = 0;
  localparam int PRIO_FIXED = 1;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_DMA = 1'b1
  } port_id_t;

  // One slot of the read-return pipe: which requester a RAM read belongs to
  typedef struct packed {
    logic     valid;
    port_id_t port;
  } rd_pipe_t;

endpackage

// File: rtl/uart_ocram_arbiter_if.sv
// rtl/uart_ocram_arbiter_if.sv - requester-side and RAM-side Avalon-MM bundles
interface uart_ocram_arbiter_if
  import uart_ocram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int BE_W   = BE_W_DEF
) ();
  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

interface uart_ocram_ram_if
  import uart_ocram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int BE_W   = BE_W_DEF
) ();
  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable;
  logic              chipselect;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              clken;
  logic [DATA_W-1:0] readdata;

  modport master (
    output address, byteenable, chipselect, write, writedata, clken,
    input  readdata
  );

  modport slave (
    input  address, byteenable, chipselect, write, writedata, clken,
    output readdata
  );
endinterface

// File: rtl/uart_ocram_rr_arb.sv
// rtl/uart_ocram_rr_arb.sv - two-requester grant logic, round-robin or fixed priority
module uart_ocram_rr_arb
  import uart_ocram_pkg::*;
#(
  parameter int PRIO_MODE    = PRIO_RR,
  parameter int STARVE_LIMIT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

  logic       last_grant;
  logic [7:0] starve_cnt;

  always_comb begin
    grant = 2'b00;
    if (!reset) begin
      if (PRIO_MODE == PRIO_RR) begin
        if (req == 2'b11) begin
          grant = last_grant ? 2'b01 : 2'b10;
        end else begin
          grant = req;
        end
      end else begin
        // DMA only overrides the CPU once it has been starved long enough
        if (req[1] && (!req[0] || (starve_cnt == STARVE_MAX))) begin
          grant = 2'b10;
        end else if (req[0]) begin
          grant = 2'b01;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
      starve_cnt <= 8'd0;
    end else begin
      if (|grant) begin
        last_grant <= grant[1];
      end
      if (!req[1] || grant[1]) begin
        starve_cnt <= 8'd0;
      end else if (starve_cnt != STARVE_MAX) begin
        starve_cnt <= starve_cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/uart_ocram_arbiter.sv
// rtl/uart_ocram_arbiter.sv - shares the single-port on-chip RAM between CPU and UART DMA
module uart_ocram_arbiter
  import uart_ocram_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int BE_W         = BE_W_DEF,
  parameter int READ_LATENCY = 1,
  parameter int PRIO_MODE    = PRIO_RR,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_ocram_arbiter_if.slave  p0,
  uart_ocram_arbiter_if.slave  p1,
  uart_ocram_ram_if.master     ram
);

  logic [1:0]        req;
  logic [1:0]        grant;
  logic [ADDR_W-1:0] mux_address;
  logic [BE_W-1:0]   mux_byteenable;
  logic              mux_write;
  logic [DATA_W-1:0] mux_writedata;
  logic              rd_issue;
  port_id_t          rd_port;
  rd_pipe_t          rd_pipe [READ_LATENCY];
  rd_pipe_t          rd_head;

  // A write with read also set is still a write; the read half is dropped
  assign req[0] = p0.read | p0.write;
  assign req[1] = p1.read | p1.write;

  uart_ocram_rr_arb #(
    .PRIO_MODE    (PRIO_MODE),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .grant (grant)
  );

  always_comb begin
    mux_address    = '0;
    mux_byteenable = '0;
    mux_write      = 1'b0;
    mux_writedata  = '0;
    rd_issue       = 1'b0;
    rd_port        = PORT_CPU;
    if (grant[0]) begin
      mux_address    = p0.address;
      mux_byteenable = p0.byteenable;
      mux_write      = p0.write;
      mux_writedata  = p0.writedata;
      rd_issue       = p0.read & ~p0.write;
      rd_port        = PORT_CPU;
    end else if (grant[1]) begin
      mux_address    = p1.address;
      mux_byteenable = p1.byteenable;
      mux_write      = p1.write;
      mux_writedata  = p1.writedata;
      rd_issue       = p1.read & ~p1.write;
      rd_port        = PORT_DMA;
    end
  end

  assign ram.address    = mux_address;
  assign ram.byteenable = mux_byteenable;
  assign ram.write      = mux_write;
  assign ram.writedata  = mux_writedata;
  assign ram.chipselect = |grant;
  assign ram.clken      = ~reset;

  // Tag each issued read with its owner and shift it along until the RAM answers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        rd_pipe[i] <= '0;
      end
    end else begin
      rd_pipe[0] <= '{valid: rd_issue, port: rd_port};
      for (int i = 1; i < READ_LATENCY; i++) begin
        rd_pipe[i] <= rd_pipe[i-1];
      end
    end
  end

  assign rd_head = rd_pipe[READ_LATENCY-1];

  assign p0.waitrequest   = reset | (req[0] & ~grant[0]);
  assign p1.waitrequest   = reset | (req[1] & ~grant[1]);
  assign p0.readdatavalid = rd_head.valid & (rd_head.port == PORT_CPU);
  assign p1.readdatavalid = rd_head.valid & (rd_head.port == PORT_DMA);
  assign p0.readdata      = ram.readdata;
  assign p1.readdata      = ram.readdata;

endmodule
